uart_tx_engine: RTL and testbench

Serializer stage directly downstream of the 8-bit TX FIFO in the APB-UART transmit path. It pops one byte when the FIFO is non-empty, then shifts it out on the tx line as an asynchronous UART frame: start bit, 5–8 data bits LSB-first, optional parity, and 1 or 2 stop bits. Frame format and bit period are captured from APB-programmed config at frame start.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_baud_cnt.sv | 27 ++
 rtl/uart_tx_engine.sv | 134 +++++++++++++
 tb/tb_uart_tx_engine.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding, word-length and parity-mode
// constants, and helpers for the TX serializer and the RX deserializer.
package uart_pkg;

  typedef logic [2:0] tx_state_t;

  localparam tx_state_t ST_IDLE   = 3'd0;
  localparam tx_state_t ST_POP    = 3'd1;
  localparam tx_state_t ST_LOAD   = 3'd2;
  localparam tx_state_t ST_START  = 3'd3;
  localparam tx_state_t ST_DATA   = 3'd4;
  localparam tx_state_t ST_PARITY = 3'd5;
  localparam tx_state_t ST_STOP   = 3'd6;

  localparam logic [1:0] WLEN_5 = 2'b00;
  localparam logic [1:0] WLEN_6 = 2'b01;
  localparam logic [1:0] WLEN_7 = 2'b10;
  localparam logic [1:0] WLEN_8 = 2'b11;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Bits of the byte that actually go on the line for a given word length.
  function automatic logic [7:0] wlen_mask(input logic [1:0] wlen);
    case (wlen)
      WLEN_5:  return 8'h1F;
      WLEN_6:  return 8'h3F;
      WLEN_7:  return 8'h7F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable bit-period down-counter; tick marks the last cycle of each
// period of div+1 clocks.
module uart_baud_cnt #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load || (cnt_reg == '0)) begin
      cnt_reg <= div;
    end else begin
      cnt_reg <= cnt_reg - DIV_W'(1);
    end
  end

  assign tick = !load && (cnt_reg == '0);

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit serializer: pops a byte from the TX FIFO and sends start,
// 5-8 data bits LSB-first, optional parity and 1 or 2 stop bits.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tx_en,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [1:0]       cfg_wlen,
  input  logic             cfg_par_en,
  input  logic             cfg_par_odd,
  input  logic             cfg_stop2,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_rdata,
  output logic             fifo_pop,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  tx_state_t        state_reg;
  logic [7:0]       shift_reg;
  logic [2:0]       bit_cnt_reg;
  logic             stop_cnt_reg;
  logic [DIV_W-1:0] div_reg;
  logic [1:0]       wlen_reg;
  logic             par_en_reg;
  logic             stop2_reg;
  logic             par_bit_reg;
  logic             tx_reg;
  logic             done_reg;

  logic             load;
  logic [DIV_W-1:0] div_sel;
  logic             tick;
  logic [2:0]       last_bit;

  // The counter loads in the same cycle the divisor is latched, so feed it
  // the live value during LOAD.
  assign load     = (state_reg == ST_LOAD);
  assign div_sel  = load ? baud_div : div_reg;
  assign last_bit = {1'b0, wlen_reg} + 3'd4;

  uart_baud_cnt #(.DIV_W(DIV_W)) u_baud_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .div   (div_sel),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      shift_reg    <= '0;
      bit_cnt_reg  <= '0;
      stop_cnt_reg <= 1'b0;
      div_reg      <= '0;
      wlen_reg     <= WLEN_5;
      par_en_reg   <= 1'b0;
      stop2_reg    <= 1'b0;
      par_bit_reg  <= 1'b0;
      tx_reg       <= 1'b1;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (tx_en && !fifo_empty) state_reg <= ST_POP;
        end
        ST_POP: state_reg <= ST_LOAD;
        ST_LOAD: begin
          shift_reg    <= fifo_rdata;
          div_reg      <= baud_div;
          wlen_reg     <= cfg_wlen;
          par_en_reg   <= cfg_par_en;
          stop2_reg    <= cfg_stop2;
          par_bit_reg  <= (^(fifo_rdata & wlen_mask(cfg_wlen))) ^ (cfg_par_odd == PAR_ODD);
          bit_cnt_reg  <= '0;
          stop_cnt_reg <= 1'b0;
          tx_reg       <= 1'b0;
          state_reg    <= ST_START;
        end
        ST_START: begin
          if (tick) begin
            tx_reg    <= shift_reg[0];
            state_reg <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_cnt_reg == last_bit) begin
              tx_reg    <= par_en_reg ? par_bit_reg : 1'b1;
              state_reg <= par_en_reg ? ST_PARITY : ST_STOP;
            end else begin
              shift_reg   <= shift_reg >> 1;
              tx_reg      <= shift_reg[1];
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            tx_reg    <= 1'b1;
            state_reg <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (stop2_reg && !stop_cnt_reg) begin
              stop_cnt_reg <= 1'b1;
            end else begin
              done_reg  <= 1'b1;
              state_reg <= ST_IDLE;
            end
          end
        end
        default: begin
          tx_reg    <= 1'b1;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign fifo_pop   = (state_reg == ST_POP);
  assign busy       = (state_reg != ST_IDLE);
  assign tx         = tx_reg;
  assign frame_done = done_reg;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: table of frame formats with
// hand-computed line patterns, plus back-to-back, tx_en, baud and reset cases.
module tb_uart_tx_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_en = 1'b0;
  logic [15:0] baud_div = 16'd0;
  logic [1:0]  cfg_wlen = 2'b00;
  logic        cfg_par_en = 1'b0;
  logic        cfg_par_odd = 1'b0;
  logic        cfg_stop2 = 1'b0;
  logic        fifo_empty;
  logic [7:0]  fifo_rdata = 8'h00;
  logic        fifo_pop, tx, busy, frame_done;

  int total = 0;
  int bad = 0;

  uart_tx_engine #(.DIV_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_en      (tx_en),
    .baud_div   (baud_div),
    .cfg_wlen   (cfg_wlen),
    .cfg_par_en (cfg_par_en),
    .cfg_par_odd(cfg_par_odd),
    .cfg_stop2  (cfg_stop2),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_pop   (fifo_pop),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // FIFO model: registered read data, one cycle after the pop.
  logic [7:0] fifo_mem [0:15];
  int head = 0;
  int tail = 0;
  int pop_empty = 0;
  assign fifo_empty = (head == tail);

  always @(posedge clk) begin
    if (fifo_pop) begin
      if (head == tail) pop_empty <= pop_empty + 1;
      else begin
        fifo_rdata <= fifo_mem[head[3:0]];
        head <= head + 1;
      end
    end
  end

  task automatic push(input logic [7:0] b);
    fifo_mem[tail[3:0]] = b;
    tail = tail + 1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Per-cycle log, sampled on the falling edge; index 1 is the first cycle.
  logic log_tx   [0:1023];
  logic log_pop  [0:1023];
  logic log_busy [0:1023];
  logic log_done [0:1023];
  int ncyc;

  task automatic capture(input int ndone, input int chg_cyc, input logic [15:0] chg_div,
                         input int drop_cyc);
    int dones;
    int extra;
    dones = 0;
    extra = -1;
    ncyc = 0;
    while (ncyc < 1000) begin
      @(negedge clk);
      ncyc++;
      if (ncyc == chg_cyc) baud_div = chg_div;
      if (ncyc == drop_cyc) tx_en = 1'b0;
      log_tx[ncyc]   = tx;
      log_pop[ncyc]  = fifo_pop;
      log_busy[ncyc] = busy;
      log_done[ncyc] = frame_done;
      if (frame_done === 1'b1) dones++;
      if (extra < 0 && dones >= ndone) extra = 6;
      if (extra > 0) begin
        extra--;
        if (extra == 0) break;
      end
    end
    check("capture_frame_done_seen", dones, ndone);
  endtask

  function automatic int count_sig(input int which, input int from, input int to);
    int n;
    logic v;
    n = 0;
    for (int c = from; c <= to; c++) begin
      case (which)
        0:       v = log_pop[c];
        1:       v = log_busy[c];
        default: v = log_done[c];
      endcase
      if (v === 1'b1) n++;
    end
    return n;
  endfunction

  function automatic int first_low(input int from);
    for (int c = from; c <= ncyc; c++)
      if (log_tx[c] === 1'b0) return c;
    return -1;
  endfunction

  function automatic int nth_done(input int k);
    int n;
    n = 0;
    for (int c = 1; c <= ncyc; c++) begin
      if (log_done[c] === 1'b1) begin
        n++;
        if (n == k) return c;
      end
    end
    return -1;
  endfunction

  task automatic get_bits(input int s, input int per, input int n,
                          output logic [11:0] bits, output int glitch);
    logic v;
    bits = '0;
    glitch = 0;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < per; j++) begin
        v = (s + i * per + j <= ncyc && s >= 0) ? log_tx[s + i * per + j] : 1'bx;
        if (j == 0) bits[i] = v;
        else if (v !== bits[i]) glitch++;
      end
    end
  endtask

  typedef struct {
    logic [15:0] div;
    logic [1:0]  wlen;
    logic        par_en;
    logic        par_odd;
    logic        stop2;
    logic [7:0]  data;
    int          n;
    logic [11:0] bits;
  } vec_t;

  vec_t vecs [7];

  task automatic run_vec(input int id, input vec_t v, input int chg_cyc,
                         input logic [15:0] chg_div, input int drop_cyc, input bit extra_byte);
    int per;
    int s;
    int glitch;
    logic [11:0] obs;
    @(negedge clk);
    baud_div    = v.div;
    cfg_wlen    = v.wlen;
    cfg_par_en  = v.par_en;
    cfg_par_odd = v.par_odd;
    cfg_stop2   = v.stop2;
    tx_en       = 1'b1;
    push(v.data);
    if (extra_byte) push(8'h3C);
    capture(1, chg_cyc, chg_div, drop_cyc);
    per = int'(v.div) + 1;
    s = first_low(1);
    get_bits(s, per, v.n, obs, glitch);
    $display("vec %0d: div=%0d wlen=%0d par=%0d odd=%0d stop2=%0d data=%h line=%h expect=%h",
             id, v.div, v.wlen, v.par_en, v.par_odd, v.stop2, v.data, obs, v.bits);
    check($sformatf("v%0d_pop_count", id), count_sig(0, 1, ncyc), 1);
    check($sformatf("v%0d_pop_cycle", id), int'(log_pop[1]), 1);
    check($sformatf("v%0d_start_cycle", id), s, 3);
    check($sformatf("v%0d_line_bits", id), int'(obs), int'(v.bits));
    check($sformatf("v%0d_bit_width_glitches", id), glitch, 0);
    check($sformatf("v%0d_busy_cycles", id), count_sig(1, 1, ncyc), 2 + v.n * per);
    check($sformatf("v%0d_done_count", id), count_sig(2, 1, ncyc), 1);
    check($sformatf("v%0d_done_cycle", id), nth_done(1), 3 + v.n * per);
    check($sformatf("v%0d_idle_high", id), int'(log_tx[ncyc]), 1);
  endtask

  initial begin
    int d;
    int s;
    int glitch;
    int viol;
    logic [11:0] obs;
    logic [7:0] b2b [3];

    //           div    wlen   pe    po    s2    data   n   line (bit0 = start)
    vecs[0] = '{16'd3, 2'b11, 1'b0, 1'b0, 1'b0, 8'hA5, 10, 12'h34A};
    vecs[1] = '{16'd2, 2'b10, 1'b1, 1'b0, 1'b0, 8'h83, 10, 12'h206};
    vecs[2] = '{16'd2, 2'b10, 1'b1, 1'b1, 1'b0, 8'h83, 10, 12'h306};
    vecs[3] = '{16'd0, 2'b00, 1'b0, 1'b0, 1'b1, 8'h1F,  8, 12'h0FE};
    vecs[4] = '{16'd1, 2'b01, 1'b1, 1'b1, 1'b1, 8'h2C, 10, 12'h358};
    vecs[5] = '{16'd0, 2'b11, 1'b1, 1'b0, 1'b1, 8'hFF, 12, 12'hDFE};
    vecs[6] = '{16'd1, 2'b00, 1'b1, 1'b0, 1'b0, 8'hE0,  8, 12'h080};

    repeat (3) @(negedge clk);
    check("reset_tx", int'(tx), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_pop", int'(fifo_pop), 0);
    check("reset_done", int'(frame_done), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i], 0, 16'd0, 0, 1'b0);

    // Divisor change during DATA: the latched period must be kept.
    run_vec(10, vecs[0], 8, 16'd0, 0, 1'b0);

    // tx_en dropped during DATA with a second byte queued.
    run_vec(11, vecs[1], 10, vecs[1].div, 10, 1'b1);
    viol = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (fifo_pop !== 1'b0 || busy !== 1'b0) viol++;
    end
    check("txen_off_no_pop", viol, 0);
    check("txen_off_fifo_kept", int'(fifo_empty), 0);
    tx_en = 1'b1;
    capture(1, 0, 16'd0, 0);
    check("txen_on_drain_pops", count_sig(0, 1, ncyc), 1);
    $display("txen case: second byte drained after re-enable");

    // Back-to-back: three bytes, 8N1, two cycles per bit.
    @(negedge clk);
    baud_div = 16'd1; cfg_wlen = 2'b11; cfg_par_en = 1'b0; cfg_stop2 = 1'b0;
    b2b[0] = 8'h11; b2b[1] = 8'h22; b2b[2] = 8'hC3;
    for (int k = 0; k < 3; k++) push(b2b[k]);
    capture(3, 0, 16'd0, 0);
    check("b2b_pop_count", count_sig(0, 1, ncyc), 3);
    check("b2b_pop_while_empty", pop_empty, 0);
    s = first_low(1);
    check("b2b_first_start", s, 3);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        d = nth_done(k);
        s = first_low(d);
        check($sformatf("b2b_gap_%0d", k), s - d, 3);
      end
      get_bits(s, 2, 10, obs, glitch);
      $display("b2b frame %0d: data=%h line=%h", k, b2b[k], obs);
      check($sformatf("b2b_bits_%0d", k), int'(obs), int'({2'b00, 1'b1, b2b[k], 1'b0}));
      check($sformatf("b2b_glitch_%0d", k), glitch, 0);
    end

    // Asynchronous reset in the middle of DATA.
    @(negedge clk);
    baud_div = 16'd3;
    push(8'h00);
    repeat (12) @(negedge clk);
    check("rst_mid_busy_before", int'(busy), 1);
    check("rst_mid_tx_before", int'(tx), 0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_tx_async", int'(tx), 1);
    check("rst_mid_busy_async", int'(busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    viol = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (fifo_pop !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) viol++;
    end
    check("rst_mid_stays_idle", viol, 0);
    check("rst_mid_no_reread", pop_empty, 0);
    $display("reset case: idle after release, pops while empty=%0d", pop_empty);

    run_vec(12, vecs[3], 0, 16'd0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
